// File: rtl/xls_stream_serializer.sv
// Purpose: width-down serializer; splits a Width-bit word into up to Ratio beats of OutWidth bits, LSB beat first.
// Latency: first beat on out_valid the cycle after the word is accepted; one beat per cycle sustained, no bubble between words.
// Backpressure: out_ready low holds the current beat stable; in_ready only rises when idle or when the last beat leaves this cycle.
//
// Ports:
//   clk, rst        single clock; asynchronous active-low reset
//   in_data         word to serialize
//   in_beats        number of valid beats in in_data (0 or > Ratio means Ratio)
//   in_valid/ready  input handshake
//   out_data        current beat
//   out_last        current beat is the final beat of its word
//   out_valid/ready output handshake
module xls_stream_serializer #(
  parameter int Width = 32,
  parameter int Ratio = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [Width-1:0]              in_data,
  input  logic [$clog2(Ratio):0]        in_beats,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [Width/Ratio-1:0]        out_data,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int OutWidth = Width / Ratio;
  localparam int CntWidth = $clog2(Ratio) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [Width-1:0]      data_q;
  logic [CntWidth-1:0]   idx_q;
  logic [CntWidth-1:0]   total_q;
  logic [CntWidth-1:0]   beats_norm;
  logic                  in_xfer;
  logic                  out_xfer;

  // A zero or oversized beat count means a full word.
  always_comb begin
    beats_norm = in_beats;
    if (in_beats == '0 || in_beats > CntWidth'(Ratio)) begin
      beats_norm = CntWidth'(Ratio);
    end
  end

  // The captured word is shifted down as beats leave, so the current beat
  // always sits in the low OutWidth bits and no wide index mux is needed.
  // Bits above the beat total are never shifted into view because the word
  // is retired (or replaced) on the last beat.
  assign out_data  = data_q[OutWidth-1:0];
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && (idx_q == total_q - CntWidth'(1));

  // in_ready depends only on state and out_ready; gating with rst keeps it
  // low for the whole reset window even though the state already reads IDLE.
  assign in_ready  = rst && ((state_q == IDLE) || (out_last && out_ready));

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          state_d = SEND;
        end
      end
      SEND: begin
        // A new word arriving on the last-beat cycle keeps us in SEND.
        if (out_xfer && out_last && !in_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data is cleared on reset so out_data reads zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      idx_q   <= '0;
      total_q <= CntWidth'(Ratio);
    end else if (in_xfer) begin
      data_q  <= in_data;
      idx_q   <= '0;
      total_q <= beats_norm;
    end else if (out_xfer && !out_last) begin
      data_q  <= data_q >> OutWidth;
      idx_q   <= idx_q + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_xls_stream_serializer.sv
module tb_xls_stream_serializer;
  localparam int W  = 32;
  localparam int R  = 4;
  localparam int OW = W / R;
  localparam int CW = $clog2(R) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_beats;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  xls_stream_serializer #(.Width(W), .Ratio(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_beats  (in_beats),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Expected beats for one accepted word.
  task automatic push_word(input logic [W-1:0] d, input logic [CW-1:0] b);
    int n;
    n = (b == 0 || b > R) ? R : int'(b);
    for (int k = 0; k < n; k++) begin
      beat_t e;
      e.d = d[k*OW +: OW];
      e.l = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: every output transfer is checked against the queue head.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data=%h last=%b, required no beat", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.d || out_last !== e.l) begin
          n_fail++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                   out_data, out_last, e.d, e.l);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [W-1:0] d, input logic [CW-1:0] b);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_beats = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        push_word(d, b);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL accept_timeout: word %h got not accepted, required accepted", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_beats  = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b required 0", out_last); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 00", out_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_in_ready: got %b required 0", in_ready); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b required 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send_word(32'hDDCCBBAA, 3'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_%0d: got %b required 1", k, out_valid); end
      n_checks++;
      if (in_ready !== (k == 3)) begin n_fail++; $display("FAIL single_in_ready_%0d: got %b required %b", k, in_ready, (k == 3)); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got out_valid=%b required 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h03020100;
    in_beats  = 3'd4;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accept: got in_ready=%b required 1", in_ready); end
    push_word(32'h03020100, 3'd4);
    @(posedge clk);
    #1;
    in_data = 32'h07060504;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %b required 1", c, out_valid); end
      n_checks++;
      if (in_ready !== (c == 3 || c == 7)) begin
        n_fail++;
        $display("FAIL b2b_in_ready_%0d: got %b required %b", c, in_ready, (c == 3 || c == 7));
      end
      if (c == 3) push_word(32'h07060504, 3'd4);
      @(posedge clk);
      #1;
      if (c == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got out_valid=%b required 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held_d;
    logic          held_l;
    int            sent;
    bit            stalled;
    sent    = 0;
    stalled = 0;
    held_d  = '0;
    held_l  = 1'b0;
    out_ready = 1'b1;
    send_word(32'h44332211, 3'd4);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b required 1", i, out_valid); end
      n_checks++;
      if (in_ready !== (out_ready && sent == 3)) begin
        n_fail++;
        $display("FAIL bp_in_ready_%0d: got %b required %b", i, in_ready, (out_ready && sent == 3));
      end
      if (stalled) begin
        n_checks++;
        if (out_data !== held_d || out_last !== held_l) begin
          n_fail++;
          $display("FAIL bp_hold_%0d: got data=%h last=%b required data=%h last=%b",
                   i, out_data, out_last, held_d, held_l);
        end
      end
      held_d  = out_data;
      held_l  = out_last;
      stalled = !out_ready;
      if (out_ready) sent++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got out_valid=%b required 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    send_word(32'h000000EE, 3'd1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_one_beat: got valid=%b last=%b required 1 1", out_valid, out_last);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL partial_one_in_ready: got %b required 1", in_ready); end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_one_idle: got out_valid=%b required 0", out_valid); end
    @(posedge clk);
    #1;
    send_word(32'h11223344, 3'd0);
    drain();
    send_word(32'hA5B6C7D8, 3'd5);
    drain();
    send_word(32'h9988FF77, 3'd3);
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_word(32'hDDCCBBAA, 3'd4);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b required 0", in_ready); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL mid_reset_out_data: got %h required 00", out_data); end
    n_checks++;
    if (exp_q.size() != 2) begin n_fail++; $display("FAIL mid_reset_progress: got %0d beats pending, required 2", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_out_valid: got %b required 0", out_valid); end
    @(posedge clk);
    #1;
    send_word(32'h0000FF00, 3'd2);
    drain();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_final_idle: got out_valid=%b required 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_partial();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_beats: got %0d, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xls_stream_serializer.md
XLS_STREAM_SERIALIZER -- requirements
Module: xls_stream_serializer

Interface
REQ-001 Parameter Width, default 32: input word width in bits.
REQ-002 Parameter Ratio, default 4: output beats per input word; Width SHALL be an integer multiple of Ratio, Ratio >= 2.
REQ-003 Derived OutWidth = Width/Ratio; CntWidth = $clog2(Ratio)+1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 in_data  input  Width  word to serialize.
REQ-007 in_beats  input  CntWidth  valid beats in in_data, counted from the LSB end.
REQ-008 in_valid  input  1  producer holds a word.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 out_data  output  OutWidth  current beat.
REQ-011 out_last  output  1  current beat is the final beat of its word.
REQ-012 out_valid  output  1  beat available.
REQ-013 out_ready  input  1  consumer takes the beat this cycle.

Function
REQ-014 The block SHALL be a two-state machine: IDLE (no word held) and SEND (word held, beats outstanding).
REQ-015 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-016 On input transfer, in_data SHALL be captured, the beat index cleared to 0, and the beat total latched from in_beats.
REQ-017 in_beats = 0 or in_beats > Ratio SHALL be treated as Ratio.
REQ-018 Latency: first beat SHALL appear on out_valid the cycle after input transfer; no combinational path in_data -> out_data.
REQ-019 Beat k SHALL be bits [k*OutWidth +: OutWidth] of the captured word, LSB beat first.
REQ-020 out_valid SHALL be 1 exactly in SEND; out_data/out_last SHALL be stable while out_valid && !out_ready.
REQ-021 out_last SHALL be 1 iff beat index = beat total - 1.
REQ-022 Each output transfer of a non-last beat SHALL increment the beat index by 1.
REQ-023 Output transfer of the last beat with no simultaneous input transfer SHALL move SEND -> IDLE.
REQ-024 in_ready SHALL equal (IDLE) or (SEND && out_last && out_ready), combinational from state and out_ready only (in_valid SHALL NOT affect it).
REQ-025 Simultaneous last-beat output transfer and input transfer SHALL stay in SEND with the new word; sustained throughput SHALL be one beat per cycle with no bubble between words.
REQ-026 IDLE with input transfer SHALL move to SEND.
REQ-027 in_beats = 1 SHALL produce a single beat with out_last = 1.
REQ-028 Captured-but-unsent bits above the beat total SHALL never be output.

Reset
REQ-029 While rst = 0: state IDLE, out_valid = 0, out_last = 0, in_ready = 0, beat index = 0, asynchronously and independent of clk.
REQ-030 out_data SHALL be 0 during reset; data register need not be cleared otherwise.
REQ-031 Reset asserted mid-word SHALL discard remaining beats; no beat of that word SHALL appear after release.
REQ-032 First rising edge after rst returns to 1 SHALL see in_ready = 1, out_valid = 0.

Verification (Width=32, Ratio=4)
REQ-033 Single word 0xDDCCBBAA, in_beats=4, out_ready=1 -> beats 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting 1 cycle after accept; out_last only on 0xDD.
REQ-034 Back-to-back words 0x03020100 and 0x07060504, in_valid held, out_ready=1 -> 8 beats 0x00..0x07 in 8 consecutive cycles, in_ready=1 on cycles of last beat, out_last on 0x03 and 0x07.
REQ-035 Backpressure: out_ready toggled 1,0,0,1,... on word 0x44332211 -> out_data held while stalled, beat order unchanged, in_ready=0 until last-beat transfer.
REQ-036 Partial words: in_beats=1 word 0x000000EE -> one beat 0xEE with out_last=1; in_beats=0 word 0x11223344 -> 4 beats 0x44,0x33,0x22,0x11.
REQ-037 Reset after 2nd beat of 0xDDCCBBAA -> out_valid/in_ready drop to 0 immediately; after release out_valid=0, next word 0x0000FF00 (in_beats=2) yields 0x00 then 0xFF, no 0xCC/0xDD.
